sobel_frame_ctrl: RTL
=====================

Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the Sobel convolution engine. On a start pulse it streams one ROI_SIZE x ROI_SIZE 8-bit frame from a word-addressed synchronous RAM into the engine's data_in. It gates the engine through clk_en so the engine only advances when the next input beat is present and downstream is not stalled. It counts output beats, computes the true per-frame maximum gradient magnitude (replacing the engine's max port, which is not used), and signals done/error.

Parameters:
ROI_SIZE, 480, frame width and height in pixels
PORT_BITS, 128, engine input port width (one RAM word per beat)
IN_WIDTH, 8, input pixel width
OUT_WIDTH, 12, engine output lane width (signed)
PIXELS_OUT_PER_CYCLE, 2, engine output lanes per valid beat
ADDR_WIDTH, 16, RAM word-address width
MEM_LAT, 1, fixed RAM read latency in cycles (>=1)
Derived: IN_NUM = PORT_BITS/IN_WIDTH; BEATS = ROI_SIZE*ROI_SIZE/IN_NUM; OUT_BEATS = ROI_SIZE*ROI_SIZE/PIXELS_OUT_PER_CYCLE; FIFO_DEPTH = MEM_LAT+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
base_addr  in  ADDR_WIDTH  RAM word address of beat 0; sampled on accepted start
out_stall  in  1  downstream back-pressure; freezes the engine while high
mem_rd_en  out  1  RAM read strobe
mem_rd_addr  out  ADDR_WIDTH  RAM read address
mem_rd_data  in  PORT_BITS  RAM data, valid MEM_LAT cycles after mem_rd_en
conv_clk_en  out  1  engine clk_en
conv_data_in  out  PORT_BITS  engine data_in (FIFO head, zero when empty)
conv_ready  in  1  engine ready
conv_valid  in  1  engine valid
conv_data_out  in  PIXELS_OUT_PER_CYCLE*OUT_WIDTH  engine lanes, lane n at [(n+1)*OUT_WIDTH-1 -: OUT_WIDTH]
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end
frame_max  out  OUT_WIDTH  max lane value of the last frame; held until next start
err  out  1  high for the done cycle if the valid-beat count != OUT_BEATS

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all FIFO, in-flight and counter state cleared; busy=0, done=0, err=0, mem_rd_en=0, mem_rd_addr=0, conv_clk_en=0, conv_data_in=0, frame_max=0. Reset mid-frame abandons the frame; no done pulse is issued.
- States: IDLE -> FEED on start. FEED -> DRAIN when consumed count reaches BEATS. DRAIN -> DONE once conv_valid has been seen high and then samples low with conv_clk_en=1. DONE -> IDLE unconditionally after 1 cycle.
- IDLE: conv_clk_en=0, so the engine is frozen. On start, latch base_addr, clear issued/consumed/out-beat counters and frame_max, and set busy=1. start while busy is ignored.
- Prefetch (FEED): mem_rd_en=1 when issued<BEATS and fifo_count+inflight<FIFO_DEPTH. mem_rd_addr = base + issued. The in-flight shift register has length MEM_LAT. Returning data is pushed into the FIFO; overflow is impossible by construction.
- Gating (FEED): conv_clk_en = !out_stall && (fifo_count!=0 || !conv_ready).
- Pop: a FIFO entry is popped and consumed++ when conv_clk_en && conv_ready. Push and pop in the same cycle leave the count unchanged.
- DRAIN: conv_clk_en = !out_stall. No reads are issued and conv_data_in=0.
- Output tracking: on a cycle with conv_clk_en && conv_valid, increment the out-beat count and update frame_max = max(frame_max, all lanes), signed compare. The update is registered, so frame_max is final in the done cycle.
- DONE: done=1 and busy=0 in the same cycle. err=(out_count!=OUT_BEATS).
- With out_stall high, conv_clk_en=0 in every state. Prefetch continues until the FIFO is full.

Test Plan:
- ROI_SIZE=32, MEM_LAT=1, RAM word k holds all bytes = k mod 256, start with base=0x100, no stall -> exactly 64 reads at addresses 0x100..0x13F, no duplicates; 512 valid beats; one done pulse; err=0; busy falls with done.
- Same frame with out_stall held high for 7 cycles at a random point in FEED and again in DRAIN -> conv_clk_en=0 throughout both stalls, no lost or repeated beat, 512 valid beats, err=0.
- MEM_LAT=3 -> inflight+fifo never exceeds 4; conv_clk_en drops only while fifo is empty and conv_ready=1; frame completes with err=0.
- Single pixel value 200 at (10,10), rest 0 -> frame_max equals the engine's peak lane output for that frame; frame_max is held after done until the next start, then cleared.
- start asserted again mid-FEED -> ignored (no address reset). rst_n asserted mid-FEED -> all outputs return to reset values immediately; the next start runs a clean full frame.
- Engine model that drops one valid beat -> done still pulses, with err=1 for that cycle only.

Source files
------------

// File: rtl/sobel_frame_ctrl_if.sv
// Bus bundle between the frame sequencer, its frame RAM read port and the Sobel engine.
// The master side is the sequencer; the slave side is the RAM/engine pair.
interface sobel_frame_ctrl_if #(
  parameter int ADDR_WIDTH           = 16,
  parameter int PORT_BITS            = 128,
  parameter int OUT_WIDTH            = 12,
  parameter int PIXELS_OUT_PER_CYCLE = 2
);
  logic                                      mem_rd_en;
  logic [ADDR_WIDTH-1:0]                     mem_rd_addr;
  logic [PORT_BITS-1:0]                      mem_rd_data;
  logic                                      conv_clk_en;
  logic [PORT_BITS-1:0]                      conv_data_in;
  logic                                      conv_ready;
  logic                                      conv_valid;
  logic [PIXELS_OUT_PER_CYCLE*OUT_WIDTH-1:0] conv_data_out;

  modport master (
    output mem_rd_en, mem_rd_addr, conv_clk_en, conv_data_in,
    input  mem_rd_data, conv_ready, conv_valid, conv_data_out
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, conv_clk_en, conv_data_in,
    output mem_rd_data, conv_ready, conv_valid, conv_data_out
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel engine: prefetches one frame from RAM into a small FIFO,
// gates the engine clock enable, counts output beats and tracks the signed per-frame maximum.
module sobel_frame_ctrl #(
  parameter int ROI_SIZE             = 480,
  parameter int PORT_BITS            = 128,
  parameter int IN_WIDTH             = 8,
  parameter int OUT_WIDTH            = 12,
  parameter int PIXELS_OUT_PER_CYCLE = 2,
  parameter int ADDR_WIDTH           = 16,
  parameter int MEM_LAT              = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic                        out_stall,
  sobel_frame_ctrl_if.master          bus,
  output logic                        busy,
  output logic                        done,
  output logic signed [OUT_WIDTH-1:0] frame_max,
  output logic                        err
);
  localparam int IN_NUM     = PORT_BITS / IN_WIDTH;
  localparam int BEATS      = ROI_SIZE * ROI_SIZE / IN_NUM;
  localparam int OUT_BEATS  = ROI_SIZE * ROI_SIZE / PIXELS_OUT_PER_CYCLE;
  localparam int FIFO_DEPTH = MEM_LAT + 1;
  localparam int BW         = $clog2(BEATS + 1);
  localparam int OW         = $clog2(OUT_BEATS + 1);
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BEATS_V     = BW'(BEATS);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BEATS - 1);
  localparam logic [OW-1:0] OUT_BEATS_V = OW'(OUT_BEATS);
  localparam logic [PW-1:0] LAST_SLOT   = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]        base_r;
  logic [BW-1:0]                issued;
  logic [BW-1:0]                consumed;
  logic [OW-1:0]                out_count;
  logic [MEM_LAT-1:0]           inflight;
  logic [PORT_BITS-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [CW-1:0]                fifo_count;
  logic                         seen_valid;
  logic signed [OUT_WIDTH-1:0]  beat_max;
  logic signed [OUT_WIDTH-1:0]  lane;
  logic                         accept;
  logic                         push;
  logic                         pop;
  logic                         beat_out;
  int                           occupancy;

  assign accept   = (state == IDLE) && start;
  assign push     = inflight[MEM_LAT-1];
  assign pop      = (state == FEED) && bus.conv_clk_en && bus.conv_ready;
  assign beat_out = bus.conv_clk_en && bus.conv_valid;

  assign bus.mem_rd_addr = base_r + ADDR_WIDTH'(issued);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reads still in the RAM pipeline count against FIFO space, so a returning word always fits.
  always_comb begin
    state_nxt        = state;
    busy             = 1'b0;
    done             = 1'b0;
    err              = 1'b0;
    bus.mem_rd_en    = 1'b0;
    bus.conv_clk_en  = 1'b0;
    bus.conv_data_in = '0;
    occupancy        = int'(fifo_count) + $countones(inflight);
    case (state)
      IDLE: begin
        if (start) state_nxt = FEED;
      end
      FEED: begin
        busy            = 1'b1;
        bus.mem_rd_en   = (issued < BEATS_V) && (occupancy < FIFO_DEPTH);
        bus.conv_clk_en = !out_stall && ((fifo_count != '0) || !bus.conv_ready);
        if (fifo_count != '0) bus.conv_data_in = fifo_mem[rd_ptr];
        if (bus.conv_clk_en && bus.conv_ready && (consumed == LAST_BEAT)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy            = 1'b1;
        bus.conv_clk_en = !out_stall;
        if (seen_valid && bus.conv_clk_en && !bus.conv_valid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = (out_count != OUT_BEATS_V);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat_max = frame_max;
    lane     = '0;
    for (int n = 0; n < PIXELS_OUT_PER_CYCLE; n++) begin
      lane = bus.conv_data_out[(n+1)*OUT_WIDTH-1 -: OUT_WIDTH];
      if (lane > beat_max) beat_max = lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r     <= '0;
      issued     <= '0;
      consumed   <= '0;
      out_count  <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      seen_valid <= 1'b0;
      frame_max  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= (inflight << 1) | MEM_LAT'(bus.mem_rd_en);
      if (bus.mem_rd_en) issued <= issued + 1'b1;
      if (push) begin
        fifo_mem[wr_ptr] <= bus.mem_rd_data;
        wr_ptr           <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
        consumed <= consumed + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (beat_out) begin
        out_count <= out_count + 1'b1;
        frame_max <= beat_max;
      end
      if ((state == DRAIN) && beat_out) seen_valid <= 1'b1;
      if (accept) begin
        base_r     <= base_addr;
        issued     <= '0;
        consumed   <= '0;
        out_count  <= '0;
        frame_max  <= '0;
        seen_valid <= 1'b0;
      end
    end
  end
endmodule
